servo_motion_sequencer: RTL
===========================

// Module: servo_motion_sequencer
// PURPOSE
//   Sequences angle commands into the servo PWM path (sw_to_angle -> angle_decoder -> comparator).
//   Accepts a target angle over a valid/ready handshake.
//   Slews the driven angle toward the target by at most STEP degrees per 20 ms PWM frame.
//   Holds for SETTLE_FRAMES frames, then pulses done; o_Angle feeds angle_decoder.angle directly.
// PARAMETERS
//   ANGLE_W        9    width of every angle bus, in degrees
//   MAX_ANGLE      180  upper clamp for targets, in degrees
//   INIT_ANGLE     90   angle driven out of reset
//   STEP           2    max degrees moved per frame (>=1)
//   SETTLE_FRAMES  3    frames held at target before done (0 allowed)
// PORTS
//   i_Clk           in   1        system clock
//   clr             in   1        synchronous active-high reset
//   i_Frame_Start   in   1        1-cycle pulse at each counter wrap (20 ms period)
//   i_Target_Valid  in   1        target offered
//   i_Target_Angle  in   ANGLE_W  requested angle, degrees
//   o_Target_Ready  out  1        sequencer can accept a target
//   i_Abort         in   1        stop the move and hold the present angle
//   o_Angle         out  ANGLE_W  angle to angle_decoder, registered
//   o_Busy          out  1        high in RAMP or SETTLE
//   o_Done          out  1        1-cycle pulse when a move completes its settle
// BEHAVIOUR
//   Reset (clr=1 at an i_Clk edge; overrides everything, including mid-move):
//     - state=IDLE, o_Angle=INIT_ANGLE, o_Target_Ready=1, o_Busy=0, o_Done=0.
//     - target register=INIT_ANGLE, settle counter=0.
//   States: IDLE, RAMP, SETTLE. All outputs are registered. o_Target_Ready=1 only in IDLE.
//   IDLE: on i_Target_Valid & o_Target_Ready, latch tgt=min(i_Target_Angle, MAX_ANGLE).
//     - tgt != o_Angle -> RAMP.
//     - tgt == o_Angle -> SETTLE.
//     - i_Abort in IDLE has no effect. i_Frame_Start in IDLE has no effect.
//   RAMP: o_Angle changes only in a cycle where i_Frame_Start=1.
//     - Each such cycle: o_Angle += min(STEP, tgt-o_Angle) if tgt>o_Angle, else o_Angle -= min(STEP, o_Angle-tgt).
//     - Difference math is done in ANGLE_W+1 bits. o_Angle never passes tgt, never wraps below 0, never exceeds MAX_ANGLE.
//     - The update that makes o_Angle==tgt moves to SETTLE in the same edge, with settle count=0.
//   SETTLE: the counter increments on each i_Frame_Start.
//     - Leaves when the counter reaches SETTLE_FRAMES; SETTLE_FRAMES=0 leaves on the first SETTLE cycle.
//     - On exit: o_Done=1 for exactly one cycle (the first IDLE cycle), o_Busy=0, o_Target_Ready=1.
//   Handshake and frame timing:
//     - A target accepted in the same cycle as i_Frame_Start takes no step that frame; the first step is on the next pulse.
//     - Valid while not ready is ignored, not queued; the requester must hold valid until ready.
//     - A new target may be accepted in the o_Done cycle.
//   Abort: i_Abort in RAMP or SETTLE -> IDLE on the next edge.
//     - o_Angle keeps its present value. No o_Done. tgt is overwritten with o_Angle.
//     - Abort and i_Frame_Start in the same cycle: abort wins and o_Angle is not stepped.
//   Latency: accept->first step = next frame pulse. Full move = ceil(|delta|/STEP) frames + SETTLE_FRAMES frames.
// TESTING
//   1 Release clr -> o_Angle=90, o_Target_Ready=1, o_Busy=0, o_Done=0 on the first cycle.
//   2 Target 100 from 90 (STEP=2):
//       - o_Angle = 92,94,96,98,100 on five successive frame pulses.
//       - Three more pulses, then one o_Done pulse; ready returns to 1.
//   3 Target 200 -> clamped to 180; o_Angle stops at exactly 180 after 45 frames.
//       Then target 0 reaches 0 with no wrap.
//   4 Odd and zero deltas:
//       - Target 89 from 90: one frame step to 89.
//       - Target equal to o_Angle: no step, o_Done after SETTLE_FRAMES pulses.
//   5 Abort during RAMP at o_Angle=94, in the same cycle as a frame pulse:
//       - o_Angle stays 94. IDLE next cycle, no o_Done. Later pulses leave o_Angle at 94.
//   6 Collisions and reset:
//       - Valid during RAMP is ignored (no handshake).
//       - Accept coincident with a frame pulse: the step is deferred one frame.
//       - clr mid-RAMP -> o_Angle=90, IDLE next cycle.

Source files
------------

// File: rtl/servo_motion_sequencer.sv
// servo_motion_sequencer
//   Accepts a target angle over a valid/ready handshake, then slews the angle
//   driven into the servo PWM path toward that target. The angle moves by at
//   most STEP degrees per PWM frame. Once it reaches the target, the block
//   holds for SETTLE_FRAMES frames and then pulses o_Done. o_Angle drives
//   angle_decoder.angle directly, so every output comes straight from a flop.
//
// Ports
//   i_Clk           system clock
//   clr             synchronous active-high reset
//   i_Frame_Start   1-cycle pulse at each 20 ms PWM frame wrap
//   i_Target_Valid  target offered
//   i_Target_Angle  requested angle, degrees (clamped to MAX_ANGLE)
//   o_Target_Ready  high only in IDLE
//   i_Abort         stop the move and hold the present angle
//   o_Angle         angle to angle_decoder
//   o_Busy          high in RAMP or SETTLE
//   o_Done          1-cycle pulse when a move completes its settle
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | holding o_Angle, ready for a new target
// RAMP   | stepping o_Angle toward tgt on each frame pulse
// SETTLE | at tgt, counting frame pulses up to SETTLE_FRAMES

module servo_motion_sequencer #(
    parameter int ANGLE_W       = 9,
    parameter int MAX_ANGLE     = 180,
    parameter int INIT_ANGLE    = 90,
    parameter int STEP          = 2,
    parameter int SETTLE_FRAMES = 3
) (
    input  logic               i_Clk,
    input  logic               clr,
    input  logic               i_Frame_Start,
    input  logic               i_Target_Valid,
    input  logic [ANGLE_W-1:0] i_Target_Angle,
    output logic               o_Target_Ready,
    input  logic               i_Abort,
    output logic [ANGLE_W-1:0] o_Angle,
    output logic               o_Busy,
    output logic               o_Done
);

    localparam int CNT_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

    localparam logic [ANGLE_W-1:0] MAX_A    = ANGLE_W'(MAX_ANGLE);
    localparam logic [ANGLE_W-1:0] INIT_A   = ANGLE_W'(INIT_ANGLE);
    localparam logic [ANGLE_W:0]   STEP_W   = (ANGLE_W + 1)'(STEP);
    localparam logic [CNT_W-1:0]   SETTLE_N = CNT_W'(SETTLE_FRAMES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state;
    logic [ANGLE_W-1:0] tgt;
    logic [CNT_W-1:0]   settle_cnt;

    logic [ANGLE_W-1:0] tgt_clamped;
    logic               ramp_up;
    logic [ANGLE_W:0]   ramp_diff;
    logic [ANGLE_W:0]   ramp_amt;
    logic [ANGLE_W:0]   ramp_wide;
    logic [ANGLE_W-1:0] ramp_next;
    logic [CNT_W-1:0]   settle_inc;

    always_comb begin
        tgt_clamped = (i_Target_Angle > MAX_A) ? MAX_A : i_Target_Angle;

        // One extra bit so the difference and the step never wrap; the step
        // is limited to the remaining distance, so o_Angle cannot overshoot.
        ramp_up   = (tgt > o_Angle);
        ramp_diff = ramp_up ? ({1'b0, tgt} - {1'b0, o_Angle})
                            : ({1'b0, o_Angle} - {1'b0, tgt});
        ramp_amt  = (ramp_diff > STEP_W) ? STEP_W : ramp_diff;
        ramp_wide = ramp_up ? ({1'b0, o_Angle} + ramp_amt)
                            : ({1'b0, o_Angle} - ramp_amt);
        ramp_next = ramp_wide[ANGLE_W-1:0];

        settle_inc = settle_cnt + 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (clr) begin
            state          <= IDLE;
            o_Angle        <= INIT_A;
            tgt            <= INIT_A;
            settle_cnt     <= '0;
            o_Target_Ready <= 1'b1;
            o_Busy         <= 1'b0;
            o_Done         <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Target_Valid && o_Target_Ready) begin
                        tgt            <= tgt_clamped;
                        settle_cnt     <= '0;
                        o_Target_Ready <= 1'b0;
                        o_Busy         <= 1'b1;
                        state          <= (tgt_clamped != o_Angle) ? RAMP : SETTLE;
                    end
                end

                RAMP: begin
                    // Abort takes priority over a coincident frame pulse.
                    if (i_Abort) begin
                        tgt            <= o_Angle;
                        o_Target_Ready <= 1'b1;
                        o_Busy         <= 1'b0;
                        state          <= IDLE;
                    end else if (i_Frame_Start) begin
                        o_Angle <= ramp_next;
                        if (ramp_next == tgt) begin
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    if (i_Abort) begin
                        tgt            <= o_Angle;
                        o_Target_Ready <= 1'b1;
                        o_Busy         <= 1'b0;
                        state          <= IDLE;
                    end else if ((settle_cnt == SETTLE_N) ||
                                 (i_Frame_Start && (settle_inc == SETTLE_N))) begin
                        // The first term covers SETTLE_FRAMES=0; otherwise the
                        // block exits on the pulse that brings the count to the limit.
                        o_Done         <= 1'b1;
                        o_Target_Ready <= 1'b1;
                        o_Busy         <= 1'b0;
                        state          <= IDLE;
                    end else if (i_Frame_Start) begin
                        settle_cnt <= settle_inc;
                    end
                end

                default: begin
                    o_Target_Ready <= 1'b1;
                    o_Busy         <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
